// File: rtl/alu_ops_pkg.sv
// ALU operation selector encodings shared by the control unit and the ALU decoder.
package alu_ops_pkg;

  localparam logic [1:0] ALUop_ADD  = 2'b00;
  localparam logic [1:0] ALUop_SUB  = 2'b01;
  localparam logic [1:0] ALUop_RR   = 2'b10;
  localparam logic [1:0] ALUop_ADDU = 2'b11;

endpackage

// File: rtl/mc_ctrl_pkg.sv
// Multicycle control unit state type and datapath mux select encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JMP    = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } cu_state_t;

  // ALU B operand select
  localparam logic [1:0] ALUSRCB_REG    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_BRANCH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/opcodes_pkg.sv
// MIPS primary opcodes (IR[31:26]) for the supported instruction subset.
package opcodes_pkg;

  localparam logic [5:0] OP_RR    = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

endpackage

// File: rtl/multicyc_cu.sv
// Control FSM for a shared multicycle MIPS datapath (RR, LW, SW, BEQ, J,
// ADDI, ADDIU). Memory accesses stall on mem_ready; every finished
// instruction pulses retire and bumps instr_count.
module multicyc_cu
  import alu_ops_pkg::*;
  import opcodes_pkg::*;
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             branch,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ir_we,
  output logic             reg_we,
  output logic             wreg_dst_sel,
  output logic             wrbck_sel,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [1:0]       aluop,
  output logic             illegal,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count
);

  cu_state_t state, state_nxt;

  // State register; reset aborts any instruction in flight.
  // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instr_count <= '0;
    else if (retire) instr_count <= instr_count + CNT_W'(1);
  end

  // Next-state and control decode; outputs stay at defaults while rst is high.
  // NOTE: every output gets a default first so no path through the case leaves a latch.
  always_comb begin
    state_nxt    = S_FETCH;
    pc_we        = 1'b0;
    branch       = 1'b0;
    iord         = 1'b0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    ir_we        = 1'b0;
    reg_we       = 1'b0;
    wreg_dst_sel = 1'b0;
    wrbck_sel    = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = ALUSRCB_REG;
    pcsrc        = PCSRC_ALU;
    aluop        = ALUop_ADD;
    illegal      = 1'b0;
    retire       = 1'b0;

    if (!rst) begin
      case (state)
        S_FETCH: begin
          // PC + 4 is computed every cycle; it is only committed with the fetch.
          mem_rd  = 1'b1;
          alusrcb = ALUSRCB_FOUR;
          if (mem_ready) begin
            ir_we     = 1'b1;
            pc_we     = 1'b1;
            state_nxt = S_DECODE;
          end else begin
            state_nxt = S_FETCH;
          end
        end
        S_DECODE: begin
          // Speculatively form the branch target so BEQ can use ALUOut.
          alusrcb = ALUSRCB_BRANCH;
          case (opcode)
            OP_LW, OP_SW:      state_nxt = S_MEMADR;
            OP_RR:             state_nxt = S_REXEC;
            OP_BEQ:            state_nxt = S_BEQ;
            OP_J:              state_nxt = S_JMP;
            OP_ADDI, OP_ADDIU: state_nxt = S_IEXEC;
            default: begin
              illegal   = 1'b1;
              retire    = 1'b1;
              state_nxt = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alusrca   = 1'b1;
          alusrcb   = ALUSRCB_IMM;
          state_nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_rd    = 1'b1;
          iord      = 1'b1;
          state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
        end
        S_MEMWB: begin
          reg_we    = 1'b1;
          wrbck_sel = 1'b1;
          retire    = 1'b1;
        end
        S_MEMWR: begin
          mem_wr = 1'b1;
          iord   = 1'b1;
          if (mem_ready) retire = 1'b1;
          else           state_nxt = S_MEMWR;
        end
        S_REXEC: begin
          alusrca   = 1'b1;
          aluop     = ALUop_RR;
          state_nxt = S_RWB;
        end
        S_RWB: begin
          reg_we       = 1'b1;
          wreg_dst_sel = 1'b1;
          retire       = 1'b1;
        end
        S_BEQ: begin
          alusrca = 1'b1;
          aluop   = ALUop_SUB;
          branch  = 1'b1;
          pcsrc   = PCSRC_ALUOUT;
          retire  = 1'b1;
        end
        S_JMP: begin
          pc_we  = 1'b1;
          pcsrc  = PCSRC_JUMP;
          retire = 1'b1;
        end
        S_IEXEC: begin
          alusrca   = 1'b1;
          alusrcb   = ALUSRCB_IMM;
          aluop     = (opcode == OP_ADDIU) ? ALUop_ADDU : ALUop_ADD;
          state_nxt = S_IWB;
        end
        S_IWB: begin
          reg_we = 1'b1;
          retire = 1'b1;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/multicyc_cu.md
Name: multicyc_cu

Overview:
Moore-style control FSM that sequences a shared multicycle MIPS datapath with one ALU, one unified memory, IR, A/B and ALUOut registers. It supports the same instruction subset as the single-cycle decoder: RR, LW, SW, BEQ, J, ADDI and ADDIU. Memory accesses use a ready handshake, so the FSM stalls on slow memory. It also provides a retire pulse and a retired-instruction counter for performance checks and verification.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
opcode  in  6  IR[31:26]; stable because IR is written only by ir_we
mem_ready  in  1  memory completes the current access this cycle
pc_we  out  1  unconditional PC write
branch  out  1  PC write if ALU zero (datapath ANDs with zero)
iord  out  1  memory address source: 0 = PC, 1 = ALUOut
mem_rd  out  1  memory read request
mem_wr  out  1  memory write request
ir_we  out  1  IR load
reg_we  out  1  register file write
wreg_dst_sel  out  1  write register: 0 = Rt, 1 = Rd
wrbck_sel  out  1  write data: 0 = ALUOut, 1 = memory data register
alusrca  out  1  ALU A: 0 = PC, 1 = register A
alusrcb  out  2  ALU B: 00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target {PC[31:28], IR[25:0], 2'b00}
aluop  out  2  ALUops package encoding (ALUop_ADD/SUB/RR/ADDU)
illegal  out  1  one-cycle pulse: unknown opcode decoded
retire  out  1  one-cycle pulse on the final cycle of each instruction
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset
  - rst asserted: state goes to FETCH asynchronously and instr_count goes to 0.
  - While rst is high, every output is forced to 0 and aluop = ALUop_ADD.
  - Reset mid-instruction aborts it with no retire.
- Defaults: every control output is 0 and aluop = ALUop_ADD unless a state listed below drives it.
- FETCH
  - Drives mem_rd=1, iord=0, alusrca=0, alusrcb=01, aluop=ADD, pcsrc=00.
  - ir_we and pc_we are asserted only when mem_ready=1 (the only Mealy terms).
  - Stays in FETCH while mem_ready=0. When mem_ready=1 it goes to DECODE.
- DECODE
  - Drives alusrca=0, alusrcb=11, aluop=ADD, so the branch target lands in ALUOut.
  - Next state by opcode:
    - LW/SW -> MEMADR
    - RR -> REXEC
    - BEQ -> BEQ
    - J -> JMP
    - ADDI/ADDIU -> IEXEC
    - other -> FETCH, with illegal=1 and retire=1.
- MEMADR: alusrca=1, alusrcb=10, aluop=ADD. LW -> MEMRD, SW -> MEMWR.
- MEMRD
  - Drives mem_rd=1, iord=1, held stable until mem_ready.
  - mem_ready=1 -> MEMWB.
- MEMWB: reg_we=1, wrbck_sel=1, wreg_dst_sel=0, retire=1 -> FETCH.
- MEMWR
  - Drives mem_wr=1, iord=1, held stable until mem_ready.
  - mem_ready=1 -> FETCH with retire=1.
- REXEC: alusrca=1, alusrcb=00, aluop=ALUop_RR -> RWB.
- RWB: reg_we=1, wreg_dst_sel=1, wrbck_sel=0, retire=1 -> FETCH.
- BEQ: alusrca=1, alusrcb=00, aluop=SUB, branch=1, pcsrc=01, retire=1 -> FETCH.
- JMP: pc_we=1, pcsrc=10, retire=1 -> FETCH.
- IEXEC: alusrca=1, alusrcb=10. aluop = ADDU if opcode==ADDIU, else ADD. -> IWB.
- IWB: reg_we=1, wreg_dst_sel=0, wrbck_sel=0, retire=1 -> FETCH.
- Unreachable state encodings -> FETCH, with outputs at defaults.
- instr_count
  - Increments by 1 on every clk edge where retire=1 (illegal counts as retired).
  - Wraps modulo 2^CNT_W.
- mem_rd and mem_wr are never high in the same cycle.
- Latency with mem_ready tied to 1:
  - 5 cycles: LW
  - 4 cycles: SW, RR, ADDI/ADDIU
  - 3 cycles: BEQ, J
  - 2 cycles: illegal
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.

Decomposition:
- Reuse the existing ALUops and Opcodes packages.
- Add a cu_state_t enum and the ALUSRCB_*/PCSRC_* constants to a shared package, mc_ctrl_pkg.
- Single module. No sub-module: next-state logic, output decode and counter are one file.

Test Plan:
- Reset then release, mem_ready=1, opcode=LW (100011)
  - States: FETCH, DECODE, MEMADR, MEMRD, MEMWB. One retire on cycle 5. instr_count=1.
  - MEMWB shows reg_we=1, wrbck_sel=1.
- SW (101011) with mem_ready held 0 for 3 cycles in MEMWR
  - mem_wr=1 and iord=1 stable for 4 cycles. retire only on the ready cycle.
  - Total 7 cycles. reg_we never 1.
- Program sequence RR, ADDIU, BEQ, J, mem_ready=1
  - Latencies 4, 4, 3, 3. instr_count=4 afterwards.
  - aluop: RR in REXEC, ADDU in IEXEC, SUB with branch=1 in BEQ.
  - JMP state shows pcsrc=10.
- FETCH stall: mem_ready=0 for 2 cycles
  - ir_we=0 and pc_we=0 during the stall. Both are 1 only in the third FETCH cycle.
- opcode=111111 in DECODE
  - illegal=1 and retire=1 for one cycle. Next state FETCH. instr_count increments.
- rst asserted asynchronously in MEMRD (between clock edges)
  - All outputs 0 immediately. After release: FETCH, instr_count=0, no retire from the aborted load.
